// File: rtl/mem_arbiter.sv
// Two-master arbiter (video priority, CPU starvation guard) in front of a single-port RAM.
// Latency: grant is combinational in the request cycle; read data returns with rvalid one cycle later.
// Backpressure: a denied requester holds req and fields until gnt; one RAM access per cycle, no queueing.
module mem_arbiter #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 16,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [RAM_ADDR_BITS-1:0] cpu_adr,
    input  logic [WIDTH-1:0]         cpu_wdata,
    output logic                     cpu_gnt,
    output logic                     cpu_rvalid,
    input  logic                     vid_req,
    input  logic                     vid_we,
    input  logic [RAM_ADDR_BITS-1:0] vid_adr,
    input  logic [WIDTH-1:0]         vid_wdata,
    output logic                     vid_gnt,
    output logic                     vid_rvalid,
    output logic [WIDTH-1:0]         rdata,
    output logic                     mem_en,
    output logic                     mem_write,
    output logic                     mem_read,
    output logic [RAM_ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;
    logic       cpu_win;
    logic       vid_win;
    logic       cpu_rvalid_q;
    logic       vid_rvalid_q;

    // CPU wins when alone or once it has been denied LIMIT cycles in a row.
    assign cpu_win = cpu_req && (!vid_req || (starve_cnt >= LIMIT));
    assign vid_win = vid_req && !cpu_win;

    assign cpu_gnt = cpu_win && !reset;
    assign vid_gnt = vid_win && !reset;

    always_comb begin
        mem_en    = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_write = cpu_we;
            mem_read  = !cpu_we;
            mem_adr   = cpu_adr;
            mem_wdata = cpu_wdata;
        end else if (vid_gnt) begin
            mem_en    = 1'b1;
            mem_write = vid_we;
            mem_read  = !vid_we;
            mem_adr   = vid_adr;
            mem_wdata = vid_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt   <= '0;
            cpu_rvalid_q <= 1'b0;
            vid_rvalid_q <= 1'b0;
        end else begin
            if (cpu_req && !cpu_gnt) begin
                if (starve_cnt < LIMIT)
                    starve_cnt <= starve_cnt + 8'd1;
            end else begin
                starve_cnt <= '0;
            end
            cpu_rvalid_q <= cpu_gnt && !cpu_we;
            vid_rvalid_q <= vid_gnt && !vid_we;
        end
    end

    // A read in flight when reset arrives must never surface as a valid.
    assign cpu_rvalid = cpu_rvalid_q && !reset;
    assign vid_rvalid = vid_rvalid_q && !reset;
    assign rdata      = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read RAM model behind it.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_adr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic        vid_req, vid_we;
    logic [15:0] vid_adr, vid_wdata;
    logic        vid_gnt, vid_rvalid;
    logic [15:0] rdata;
    logic        mem_en, mem_write, mem_read;
    logic [15:0] mem_adr, mem_wdata, mem_rdata;

    logic [15:0] ram [0:1023];

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.WIDTH(16), .RAM_ADDR_BITS(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .vid_req(vid_req), .vid_we(vid_we), .vid_adr(vid_adr), .vid_wdata(vid_wdata),
        .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_write(mem_write), .mem_read(mem_read),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_write) ram[mem_adr[9:0]] <= mem_wdata;
            if (mem_read)  mem_rdata <= ram[mem_adr[9:0]];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pc, pv, ec, ev;
        for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
        ram[10'h100] = 16'h1111;
        ram[10'h200] = 16'h2222;
        mem_rdata = 16'h0000;

        // Reset with both masters requesting reads.
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0200; cpu_wdata = 16'h0000;
        vid_req = 1'b1; vid_we = 1'b0; vid_adr = 16'h0100; vid_wdata = 16'h0000;
        for (int r = 0; r < 2; r++) begin
            #1;
            check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
            check("rst_vid_gnt", 32'(vid_gnt), 32'd0);
            check("rst_mem_en", 32'(mem_en), 32'd0);
            check("rst_rw", {30'd0, mem_write, mem_read}, 32'd0);
            check("rst_rvalid", {30'd0, cpu_rvalid, vid_rvalid}, 32'd0);
            step();
        end
        reset = 1'b0;
        check("rst_starve", 32'(dut.starve_cnt), 32'd0);

        // Contention: video cycles 1-4, CPU 5, video 6-9, CPU 10, video 11.
        pc = 1'b0; pv = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            #1;
            ec = (c == 5) || (c == 10);
            ev = !ec;
            check($sformatf("st_cpu_gnt_c%0d", c), 32'(cpu_gnt), 32'(ec));
            check($sformatf("st_vid_gnt_c%0d", c), 32'(vid_gnt), 32'(ev));
            check($sformatf("st_adr_c%0d", c), 32'(mem_adr), ec ? 32'h200 : 32'h100);
            check($sformatf("st_cpu_rv_c%0d", c), 32'(cpu_rvalid), 32'(pc));
            check($sformatf("st_vid_rv_c%0d", c), 32'(vid_rvalid), 32'(pv));
            if (pc) check($sformatf("st_rdata_cpu_c%0d", c), 32'(rdata), 32'h2222);
            if (pv) check($sformatf("st_rdata_vid_c%0d", c), 32'(rdata), 32'h1111);
            pc = ec; pv = ev;
            step();
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        #1;
        check("idle_mem_en", 32'(mem_en), 32'd0);
        check("idle_adr_wdata", {mem_adr, mem_wdata}, 32'd0);
        check("idle_vid_rv", 32'(vid_rvalid), 32'd1);
        check("idle_rdata", 32'(rdata), 32'h1111);
        step();

        // CPU-only write then read back.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0010; cpu_wdata = 16'hBEEF;
        #1;
        check("wr_gnt", {30'd0, cpu_gnt, vid_gnt}, 32'd2);
        check("wr_rw", {30'd0, mem_write, mem_read}, 32'd2);
        check("wr_bus", {mem_adr, mem_wdata}, 32'h0010BEEF);
        step();
        cpu_we = 1'b0;
        #1;
        check("rd_gnt", 32'(cpu_gnt), 32'd1);
        check("rd_rw", {30'd0, mem_write, mem_read}, 32'd1);
        check("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        step();
        cpu_req = 1'b0;
        #1;
        check("rd_rvalid", {30'd0, cpu_rvalid, vid_rvalid}, 32'd2);
        check("rd_rdata", 32'(rdata), 32'hBEEF);
        step();

        // Interleaved tagging.
        vid_req = 1'b1; vid_adr = 16'h0100;
        #1;
        check("il_vid_gnt", 32'(vid_gnt), 32'd1);
        step();
        vid_req = 1'b0; cpu_req = 1'b1; cpu_adr = 16'h0200;
        #1;
        check("il_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("il_vid_rv", {30'd0, cpu_rvalid, vid_rvalid}, 32'd1);
        check("il_vid_rdata", 32'(rdata), 32'h1111);
        step();
        cpu_req = 1'b0;
        #1;
        check("il_cpu_rv", {30'd0, cpu_rvalid, vid_rvalid}, 32'd2);
        check("il_cpu_rdata", 32'(rdata), 32'h2222);
        step();

        // Withdrawal clears the starvation count.
        vid_req = 1'b1; cpu_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("wd_starve_%0d", c), 32'(dut.starve_cnt), 32'(c));
            check($sformatf("wd_deny_%0d", c), 32'(cpu_gnt), 32'd0);
            step();
        end
        cpu_req = 1'b0;
        #1;
        check("wd_starve_held", 32'(dut.starve_cnt), 32'd3);
        step();
        cpu_req = 1'b1;
        #1;
        check("wd_starve_cleared", 32'(dut.starve_cnt), 32'd0);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("wd_cpu_gnt_%0d", c), 32'(cpu_gnt), (c == 4) ? 32'd1 : 32'd0);
            check($sformatf("wd_vid_gnt_%0d", c), 32'(vid_gnt), (c == 4) ? 32'd0 : 32'd1);
            step();
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        step();

        // Reset lands on the cycle after a CPU read grant.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0200;
        #1;
        check("mr_gnt", 32'(cpu_gnt), 32'd1);
        step();
        cpu_req = 1'b0; reset = 1'b1;
        #1;
        check("mr_rv_in_reset", 32'(cpu_rvalid), 32'd0);
        check("mr_mem_en", 32'(mem_en), 32'd0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("mr_rv_after_%0d", c), {30'd0, cpu_rvalid, vid_rvalid}, 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port, clocked 16-bit data RAM between two requesters: the CPU and the video/display scanout engine.
- Sits between both masters and the RAM's en/memwrite/memread/adr/writedata/memdata interface.
- Issues at most one RAM access per cycle and steers read data back with a per-requester valid pulse.
- Video has priority; a starvation counter guarantees the CPU forward progress.

Parameters:
- WIDTH, 16: data width.
- RAM_ADDR_BITS, 16: address width.
- STARVE_LIMIT, 4: consecutive denied CPU cycles before the CPU is force-granted. Legal range 1..255.

Ports:
- clk  in  1  system clock; all state on posedge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held with its fields until cpu_gnt
- cpu_we  in  1  1=write, 0=read
- cpu_adr  in  RAM_ADDR_BITS  CPU address
- cpu_wdata  in  WIDTH  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  rdata holds CPU read result this cycle
- vid_req  in  1  video request
- vid_we  in  1  video write (normally 0)
- vid_adr  in  RAM_ADDR_BITS  video address
- vid_wdata  in  WIDTH  video write data
- vid_gnt  out  1  video request accepted this cycle
- vid_rvalid  out  1  rdata holds video read result this cycle
- rdata  out  WIDTH  read data returned to requesters (passthrough of mem_rdata)
- mem_en  out  1  RAM enable
- mem_write  out  1  RAM memwrite
- mem_read  out  1  RAM memread
- mem_adr  out  RAM_ADDR_BITS  RAM address
- mem_wdata  out  WIDTH  RAM write data
- mem_rdata  in  WIDTH  RAM memdata (registered inside RAM, valid the cycle after a read)

Behaviour:
- Grant decision is combinational from the current requests and starve_cnt.
- At most one of cpu_gnt and vid_gnt is high in any cycle.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active and starve_cnt < STARVE_LIMIT: video is granted.
  - Both active and starve_cnt == STARVE_LIMIT: CPU is granted.
- starve_cnt (8-bit register):
  - Increments when cpu_req=1 and cpu_gnt=0.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on cpu_gnt or when cpu_req=0.
- RAM drive during a granted cycle:
  - mem_en=1.
  - mem_write = granted requester's we; mem_read = its inverse.
  - mem_adr and mem_wdata are muxed from the granted requester.
- RAM drive with no grant: mem_en=mem_write=mem_read=0, mem_adr=0, mem_wdata=0.
- Read latency: a read granted in cycle N produces rvalid of the matching requester, registered, high for exactly cycle N+1.
  - rdata = mem_rdata in that cycle.
  - Writes produce no rvalid; write data is committed at the posedge ending cycle N.
- Back-to-back: a new grant may occur every cycle. Reads granted in N and N+1 give rvalid in N+1 and N+2, each tagged to the correct requester.
- Handshake: a requester keeps req and its fields stable until it sees gnt. Deasserting req before gnt withdraws the request with no side effects.
- Reset (synchronous, active-high):
  - While reset=1: cpu_gnt=vid_gnt=0 and mem_en=mem_write=mem_read=0.
  - At the clock edge with reset=1: starve_cnt=0, cpu_rvalid=vid_rvalid=0.
  - A read granted the cycle before reset asserts gets no rvalid after reset.
  - First grant is possible in the first cycle with reset=0.
- rdata is a passthrough and has no reset value; consumers qualify it with rvalid.

Test Plan:
- Reset: hold reset 2 cycles with both requests high -> no gnt, mem_en=0, rvalids=0, starve_cnt=0; first grant goes to video in the cycle reset drops.
- CPU-only write then read: cpu write adr=0x0010, wdata=0xBEEF in cycle 1 (cpu_gnt=1, mem_write=1); cpu read adr=0x0010 in cycle 2 -> cpu_rvalid=1 in cycle 3 with rdata=0xBEEF; vid_rvalid stays 0.
- Priority and starvation (STARVE_LIMIT=4): both requesting continuously with reads ->
  - vid_gnt in cycles 1-4, cpu_gnt in cycle 5, vid_gnt in cycles 6-9, cpu_gnt in cycle 10.
  - Each rvalid follows its own grant by one cycle.
- Interleaved tagging: video reads 0x0100 (data 0x1111) in cycle 1, CPU reads 0x0200 (data 0x2222) in cycle 2 -> vid_rvalid with 0x1111 in cycle 2, cpu_rvalid with 0x2222 in cycle 3.
- Withdrawal and counter clear: cpu_req high 3 denied cycles (video busy), then low 1 cycle, then high again with video busy -> starve_cnt restarts from 0; CPU is force-granted only after 4 further denied cycles.
- Reset mid-read: grant a CPU read in cycle N, assert reset in cycle N+1 -> cpu_rvalid stays 0 from N+1 onward, no spurious valid after reset releases.
